dbus_uncached: RTL



---
 rtl/dbus_uncached.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dbus_uncached.sv
// dbus_uncached: uncached data-bus responder between the execute/writeback
// stages and an SRAM-like external bus.
//
// Stores are posted into a small in-order circular write buffer and are
// acknowledged in the same cycle unless the buffer is full. Loads are issued
// as a single outstanding bus transaction, only once the buffer has fully
// drained. This keeps every load ordered behind all earlier stores.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset (0 = reset)
//   dcache_req_read/write    load / store request (never both at once)
//   dcache_req_paddr/be      physical byte address and byte enables
//   dcache_req_wrdata        store data
//   dbus_ready               store accepted / load data valid this cycle
//   dcache_resp_rddata       returned load data (registered)
//   bus_req/wr/be/addr/wdata external bus request (word-aligned address)
//   bus_addr_ok/data_ok      external address / data phase handshakes
//   bus_rdata                external read data, valid with bus_data_ok
module dbus_uncached #(
    parameter int WBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dcache_req_read,
    input  logic        dcache_req_write,
    input  logic [31:0] dcache_req_paddr,
    input  logic [3:0]  dcache_req_be,
    input  logic [31:0] dcache_req_wrdata,
    output logic        dbus_ready,
    output logic [31:0] dcache_resp_rddata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_ADDR,
        S_W_DATA,
        S_R_ADDR,
        S_R_DATA,
        S_R_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [31:0]        rddata_q, rddata_d;
    logic [31:0]        rd_addr_q, rd_addr_d;
    logic [3:0]         rd_be_q, rd_be_d;

    // Write-buffer storage; contents are only meaningful between head and tail.
    logic [31:0]        wb_addr_q [WBUF_DEPTH];
    logic [31:0]        wb_addr_d [WBUF_DEPTH];
    logic [3:0]         wb_be_q   [WBUF_DEPTH];
    logic [3:0]         wb_be_d   [WBUF_DEPTH];
    logic [31:0]        wb_data_q [WBUF_DEPTH];
    logic [31:0]        wb_data_d [WBUF_DEPTH];

    logic        full;
    logic        push;
    logic        pop;
    logic [31:0] word_addr;

    assign word_addr = dcache_req_paddr & 32'hFFFF_FFFC;
    // Fullness uses the registered count only, so a pop in the same cycle
    // never makes room for a push.
    assign full = (count_q == CNT_W'(WBUF_DEPTH));
    assign push = rst && dcache_req_write && !full;
    assign pop  = ((state_q == S_W_ADDR) && bus_addr_ok && bus_data_ok) ||
                  ((state_q == S_W_DATA) && bus_data_ok);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        head_d    = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d    = push ? tail_q + PTR_W'(1) : tail_q;
        rddata_d  = rddata_q;
        rd_addr_d = rd_addr_q;
        rd_be_d   = rd_be_q;
        wb_addr_d = wb_addr_q;
        wb_be_d   = wb_be_q;
        wb_data_d = wb_data_q;

        if (push) begin
            wb_addr_d[tail_q] = word_addr;
            wb_be_d[tail_q]   = dcache_req_be;
            wb_data_d[tail_q] = dcache_req_wrdata;
        end

        unique case (state_q)
            S_IDLE: begin
                // A store being pushed this cycle already counts as buffered,
                // so its bus request appears on the very next cycle.
                if (count_q != '0 || push) begin
                    state_d = S_W_ADDR;
                end else if (dcache_req_read) begin
                    state_d   = S_R_ADDR;
                    rd_addr_d = word_addr;
                    rd_be_d   = dcache_req_be;
                end
            end
            S_W_ADDR: begin
                if (bus_addr_ok && bus_data_ok) state_d = S_IDLE;
                else if (bus_addr_ok)           state_d = S_W_DATA;
            end
            S_W_DATA: begin
                if (bus_data_ok) state_d = S_IDLE;
            end
            S_R_ADDR: begin
                if (bus_addr_ok && bus_data_ok) begin
                    state_d  = S_R_DONE;
                    rddata_d = bus_rdata;
                end else if (bus_addr_ok) begin
                    state_d = S_R_DATA;
                end
            end
            S_R_DATA: begin
                if (bus_data_ok) begin
                    state_d  = S_R_DONE;
                    rddata_d = bus_rdata;
                end
            end
            S_R_DONE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_be    = 4'b0;
        bus_addr  = 32'b0;
        bus_wdata = 32'b0;
        if (rst) begin
            if (state_q == S_W_ADDR) begin
                bus_req   = 1'b1;
                bus_wr    = 1'b1;
                bus_be    = wb_be_q[head_q];
                bus_addr  = wb_addr_q[head_q];
                bus_wdata = wb_data_q[head_q];
            end else if (state_q == S_R_ADDR) begin
                bus_req  = 1'b1;
                bus_be   = rd_be_q;
                bus_addr = rd_addr_q;
            end
        end
    end

    always_comb begin
        dbus_ready = 1'b0;
        if (rst) begin
            if (dcache_req_write)     dbus_ready = !full;
            else if (dcache_req_read) dbus_ready = (state_q == S_R_DONE);
            else                      dbus_ready = 1'b1;
        end
    end

    assign dcache_resp_rddata = rddata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            rddata_q  <= 32'b0;
            rd_addr_q <= 32'b0;
            rd_be_q   <= 4'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            rddata_q  <= rddata_d;
            rd_addr_q <= rd_addr_d;
            rd_be_q   <= rd_be_d;
        end
    end

    // Buffer storage carries no reset; head/tail/count define what is valid.
    always_ff @(posedge clk) begin
        wb_addr_q <= wb_addr_d;
        wb_be_q   <= wb_be_d;
        wb_data_q <= wb_data_d;
    end

endmodule
